// File: rtl/uart_load_pkg.sv
// Shared types and constants for the UART program-load controller:
// FSM state encoding, default sync marker and frame field widths.
package uart_load_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4
  } load_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int LEN_W  = 16;
  localparam int CSUM_W = 8;
  localparam int WORD_W = 32;

  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                 input logic [7:0]        b);
    return acc + b;
  endfunction

endpackage

// File: rtl/load_word_asm.sv
// Payload word assembler: shifts bytes MSB-first into a 32-bit word, counts
// bytes within the word and keeps the running mod-256 payload checksum.
module load_word_asm
  import uart_load_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              last_byte,
  output logic              word_ready,
  output logic [WORD_W-1:0] word,
  output logic [CSUM_W-1:0] checksum
);

  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CSUM_W-1:0] csum_q, csum_d;
  logic              word_ready_q, word_ready_d;

  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    csum_d       = csum_q;
    word_ready_d = 1'b0;
    if (clear) begin
      byte_cnt_d = 2'd0;
      word_d     = 32'd0;
      csum_d     = 8'd0;
    end else if (in_valid) begin
      word_d       = {word_q[23:0], in_byte};
      csum_d       = csum_add(csum_q, in_byte);
      byte_cnt_d   = byte_cnt_q + 2'd1;
      word_ready_d = (byte_cnt_q == 2'd3);
    end else begin
      word_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q   <= 2'd0;
      word_q       <= 32'd0;
      csum_q       <= 8'd0;
      word_ready_q <= 1'b0;
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      word_ready_q <= word_ready_d;
    end
  end

  // Combinational so the FSM can leave DATA on the very byte that ends the last word.
  assign last_byte  = in_valid & (byte_cnt_q == 2'd3);
  assign word_ready = word_ready_q;
  assign word       = word_q;
  assign checksum   = csum_q;

endmodule

// File: rtl/uart_load_ctrl.sv
// Framed program loader: sync/length/payload/checksum parser, ROM write strobes
// and loader/CPU ROM-port arbitration. Optional inter-byte timeout: UART_LOAD_TIMEOUT_EN.
module uart_load_ctrl
  import uart_load_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned MAX_WORDS   = 4096,
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  output logic        rom_ce,
  output logic        rom_wen,
  output logic [31:0] rom_addr,
  output logic [31:0] rom_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  load_state_e       state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  word_idx_q, word_idx_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic              asm_clear_s, asm_valid_s, asm_last_s, word_ready_s;
  logic [WORD_W-1:0] asm_word_s;
  logic [CSUM_W-1:0] asm_csum_s;
  logic [LEN_W-1:0]  len_lo_s;
  logic              timeout_s;

  assign asm_valid_s = rx_valid & (state_q == DATA);
  assign len_lo_s    = {len_q[15:8], rx_data};

  load_word_asm u_asm (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .clear      (asm_clear_s),
    .in_valid   (asm_valid_s),
    .in_byte    (rx_data),
    .last_byte  (asm_last_s),
    .word_ready (word_ready_s),
    .word       (asm_word_s),
    .checksum   (asm_csum_s)
  );

`ifdef UART_LOAD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (rx_valid || (state_q == IDLE)) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign timeout_s = !rx_valid && (state_q != IDLE) &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_s = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_idx_d  = word_ready_s ? (word_idx_q + 16'd1) : word_idx_q;
    cpu_hold_d  = cpu_hold_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;
    asm_clear_s = 1'b0;
    if (timeout_s) begin
      state_d    = IDLE;
      load_err_d = 1'b1;
      cpu_hold_d = 1'b0;
    end else if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d     = LEN_HI;
            cpu_hold_d  = 1'b1;
            load_done_d = 1'b0;
            load_err_d  = 1'b0;
            word_idx_d  = 16'd0;
            asm_clear_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        LEN_HI: begin
          len_d   = {rx_data, 8'h00};
          state_d = LEN_LO;
        end
        LEN_LO: begin
          len_d = len_lo_s;
          if ({16'd0, len_lo_s} > MAX_WORDS) begin
            load_err_d = 1'b1;
            cpu_hold_d = 1'b0;
            state_d    = IDLE;
          end else if (len_lo_s == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          // word_idx_q still names the word whose last byte is arriving now.
          if (asm_last_s && ((word_idx_q + 16'd1) == len_q)) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
        CSUM: begin
          if (rx_data == asm_csum_s) begin
            load_done_d = 1'b1;
          end else begin
            load_err_d = 1'b1;
          end
          cpu_hold_d = 1'b0;
          state_d    = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      len_q       <= 16'd0;
      word_idx_q  <= 16'd0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign rom_ce    = cpu_hold_q ? word_ready_s : cpu_ce_i;
  assign rom_wen   = cpu_hold_q & word_ready_s;
  assign rom_addr  = cpu_hold_q ? {16'd0, word_idx_q} : cpu_addr_i;
  assign rom_data  = (cpu_hold_q & word_ready_s) ? asm_word_s : 32'd0;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_uart_load_ctrl.sv
// Randomised frame bench for uart_load_ctrl: frame-level reference model feeds an
// expected-write queue that a separate monitor drains on every ROM write strobe.
module tb_uart_load_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic        rom_ce, rom_wen, cpu_hold, load_done, load_err;
  logic [31:0] rom_addr, rom_data;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  always #5 sys_clk = ~sys_clk;

  uart_load_ctrl #(
    .SYNC_BYTE   (8'hA5),
    .MAX_WORDS   (4096),
    .TIMEOUT_CYC (100)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_addr_i (cpu_addr_i),
    .rom_ce     (rom_ce),
    .rom_wen    (rom_wen),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge sys_clk) begin
    if (sys_rst_n === 1'b1) begin
      if (rom_wen === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: addr %h data %h, none expected", rom_addr, rom_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", rom_addr, e.addr);
          chk("wr_data", rom_data, e.data);
          chk1("wr_ce", rom_ce, 1'b1);
        end
      end
      if (cpu_hold === 1'b1) chk1("ce_while_hold", rom_ce, rom_wen);
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      tick();
      rx_valid = 1'b0;
    end
    tick();
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      rx_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    cpu_ce_i   = 1'b0;
    cpu_addr_i = 32'd0;
    rx_valid   = 1'b0;
    rx_data    = 8'd0;
    sys_rst_n  = 1'b0;
    #1;
    chk1("rst_rom_ce", rom_ce, 1'b0);
    chk1("rst_rom_wen", rom_wen, 1'b0);
    chk("rst_rom_addr", rom_addr, 32'd0);
    chk("rst_rom_data", rom_data, 32'd0);
    chk1("rst_cpu_hold", cpu_hold, 1'b0);
    chk1("rst_load_done", load_done, 1'b0);
    chk1("rst_load_err", load_err, 1'b0);
    tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  // Frame-level model: length rule, big-endian words at consecutive addresses,
  // mod-256 sum of payload bytes against the trailing checksum byte.
  task automatic run_frame(input int n, input logic [7:0] pay[$], input logic [7:0] csum,
                           input int maxgap, input int garbage);
    logic [15:0] nn;
    logic [7:0]  sum;
    logic [7:0]  b;
    logic        exp_done;
    logic [31:0] a;
    wr_t         w;
    nn  = n[15:0];
    sum = 8'd0;
    if (n > 4096) begin
      exp_done = 1'b0;
    end else begin
      for (int i = 0; i < n; i++) begin
        w.addr = i;
        w.data = {pay[4*i], pay[4*i+1], pay[4*i+2], pay[4*i+3]};
        exp_q.push_back(w);
      end
      foreach (pay[i]) sum += pay[i];
      exp_done = (csum == sum);
    end
    cpu_ce_i   = 1'b1;
    cpu_addr_i = 32'h40;
    for (int g = 0; g < garbage; g++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h5A;
      send(b, $urandom_range(0, maxgap));
    end
    send(8'hA5, $urandom_range(0, maxgap));
    send(nn[15:8], $urandom_range(0, maxgap));
    chk1("hold_in_frame", cpu_hold, 1'b1);
    send(nn[7:0], $urandom_range(0, maxgap));
    if (n <= 4096) begin
      foreach (pay[i]) send(pay[i], $urandom_range(0, maxgap));
      send(csum, $urandom_range(0, maxgap));
    end
    idle(3);
    chk1("load_done", load_done, exp_done);
    chk1("load_err", load_err, !exp_done);
    chk1("hold_after", cpu_hold, 1'b0);
    chk("writes_left", exp_q.size(), 32'd0);
    a          = $urandom;
    cpu_addr_i = a;
    #1;
    chk1("arb_ce", rom_ce, 1'b1);
    chk("arb_addr", rom_addr, a);
    chk1("arb_wen", rom_wen, 1'b0);
    chk("arb_data", rom_data, 32'd0);
    cpu_addr_i = 32'h40;
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

  initial begin
    logic [7:0] pq[$];
    wr_t        w;

    do_reset();

    pq = '{8'h00, 8'h00, 8'h00, 8'h13, 8'h12, 8'h34, 8'h56, 8'h78};
    run_frame(2, pq, 8'h27, 0, 0);
    run_frame(2, pq, 8'h28, 1, 1);
    pq = {};
    run_frame(4097, pq, 8'h00, 0, 0);
    run_frame(0, pq, 8'h00, 0, 2);

    // Reset in the middle of a payload: first word is already in ROM.
    cpu_ce_i   = 1'b1;
    cpu_addr_i = 32'h40;
    w.addr = 32'd0;
    w.data = 32'h11223344;
    exp_q.push_back(w);
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h03, 0);
    pq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    foreach (pq[i]) send(pq[i], 0);
    idle(2);
    chk("mid_writes_left", exp_q.size(), 32'd0);
    chk1("mid_hold", cpu_hold, 1'b1);
    do_reset();
    pq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(1, pq, 8'hDE + 8'hAD + 8'hBE + 8'hEF, 0, 0);

    // Stall after two payload bytes.
    cpu_ce_i = 1'b1;
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h01, 0);
    send(8'h02, 0);
    idle(99);
    chk1("tmo_pre_err", load_err, 1'b0);
    chk1("tmo_pre_hold", cpu_hold, 1'b1);
    idle(2);
`ifdef UART_LOAD_TIMEOUT_EN
    chk1("tmo_err", load_err, 1'b1);
    chk1("tmo_hold", cpu_hold, 1'b0);
`else
    chk1("notmo_err", load_err, 1'b0);
    chk1("notmo_hold", cpu_hold, 1'b1);
`endif
    do_reset();

    for (int f = 0; f < 40; f++) begin
      int         n;
      logic [7:0] s;
      logic [7:0] cs;
      n = $urandom_range(0, 5);
      if ($urandom_range(0, 7) == 0) n = $urandom_range(4097, 65535);
      pq = {};
      if (n <= 4096) begin
        for (int i = 0; i < 4 * n; i++) pq.push_back(8'($urandom_range(0, 255)));
      end
      if (pq.size() > 0 && $urandom_range(0, 3) == 0) pq[0] = 8'hA5;
      s = 8'd0;
      foreach (pq[i]) s += pq[i];
      cs = ($urandom_range(0, 1) == 1) ? s : (s + 8'd1);
      run_frame(n, pq, cs, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    idle(2);
    chk("final_writes_left", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
